// File: rtl/spiker_writer.sv
// Output-spike accumulator + argmax; result N_OUT+1 cycles after the final accumulating cycle, irq on first DONE cycle.
// No backpressure: valid/done/start/clear are single-cycle pulses sampled every cycle, inputs ignored outside their state.
module spiker_writer #(
    parameter int N_OUT     = 10,
    parameter int CNT_WIDTH = 16,
    parameter int N_STEPS   = 25,
    parameter int CLS_W     = $clog2(N_OUT),
    parameter int STEP_W    = $clog2(N_STEPS + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       test_mode_i,
    input  logic                       start_i,
    input  logic                       clear_i,
    input  logic                       out_valid_i,
    input  logic [N_OUT-1:0]           out_spikes_i,
    input  logic                       done_i,
    output logic [N_OUT*CNT_WIDTH-1:0] counts_o,
    output logic [CLS_W-1:0]           class_o,
    output logic [CNT_WIDTH-1:0]       max_count_o,
    output logic [STEP_W-1:0]          steps_o,
    output logic                       busy_o,
    output logic                       result_valid_o,
    output logic                       overflow_o,
    output logic                       irq_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(N_STEPS - 1);
    localparam logic [CLS_W-1:0]     IDX_LAST  = CLS_W'(N_OUT - 1);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt [N_OUT];
    logic [CNT_WIDTH-1:0] cnt_inc [N_OUT];
    logic [STEP_W-1:0]    steps;
    logic [CLS_W-1:0]     scan_idx;
    logic [CLS_W-1:0]     best_idx;
    logic [CNT_WIDTH-1:0] best_val;
    logic [CLS_W-1:0]     class_q;
    logic [CNT_WIDTH-1:0] max_q;
    logic                 overflow;
    logic                 busy;
    logic                 result_valid;
    logic                 irq;
    logic                 sat_hit;
    logic [CNT_WIDTH-1:0] scan_val;
    logic                 take;
    logic                 unused_test_mode;

    assign unused_test_mode = test_mode_i;

    // Saturating per-neuron increment; a spike landing on a full counter flags overflow.
    always_comb begin
        sat_hit = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            cnt_inc[k] = cnt[k];
            if (out_spikes_i[k]) begin
                if (cnt[k] == CNT_MAX) begin
                    sat_hit = 1'b1;
                end else begin
                    cnt_inc[k] = cnt[k] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Neuron 0 always seeds the best; later neurons must be strictly larger, so ties keep the lowest index.
    assign scan_val = cnt[scan_idx];
    assign take     = (scan_idx == '0) || (scan_val > best_val);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            for (int k = 0; k < N_OUT; k++) cnt[k] <= '0;
            steps        <= '0;
            scan_idx     <= '0;
            best_idx     <= '0;
            best_val     <= '0;
            class_q      <= '0;
            max_q        <= '0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            irq          <= 1'b0;
        end else begin
            irq <= 1'b0;
            if (clear_i) begin
                if (state == ACCUM || state == SCAN) begin
                    for (int k = 0; k < N_OUT; k++) cnt[k] <= '0;
                    steps    <= '0;
                    overflow <= 1'b0;
                end
                state        <= IDLE;
                busy         <= 1'b0;
                result_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start_i) begin
                            for (int k = 0; k < N_OUT; k++) cnt[k] <= '0;
                            steps        <= '0;
                            overflow     <= 1'b0;
                            class_q      <= '0;
                            max_q        <= '0;
                            state        <= ACCUM;
                            busy         <= 1'b1;
                            result_valid <= 1'b0;
                        end
                    end
                    ACCUM: begin
                        if (out_valid_i) begin
                            for (int k = 0; k < N_OUT; k++) cnt[k] <= cnt_inc[k];
                            if (sat_hit) overflow <= 1'b1;
                            steps <= steps + STEP_W'(1);
                        end
                        if ((out_valid_i && steps == STEP_LAST) || done_i) begin
                            state    <= SCAN;
                            scan_idx <= '0;
                        end
                    end
                    SCAN: begin
                        if (take) begin
                            best_val <= scan_val;
                            best_idx <= scan_idx;
                        end
                        if (scan_idx == IDX_LAST) begin
                            class_q      <= take ? scan_idx : best_idx;
                            max_q        <= take ? scan_val : best_val;
                            state        <= DONE;
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                            irq          <= 1'b1;
                        end else begin
                            scan_idx <= scan_idx + CLS_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_counts
        assign counts_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
    end

    assign class_o        = class_q;
    assign max_count_o    = max_q;
    assign steps_o        = steps;
    assign busy_o         = busy;
    assign result_valid_o = result_valid;
    assign overflow_o     = overflow;
    assign irq_o          = irq;

endmodule

// File: doc/spiker_writer.md
Name: spiker_writer

Overview:
- Downstream stage of the spike input reader; consumes the output-layer spikes the spiker core emits once per time step.
- Accumulates a per-neuron spike count over one inference, then finds the winning class with a sequential argmax scan.
- Presents counts, class, status and a one-cycle interrupt, mapped to hw2reg fields in the adapter wrapper.

Parameters:
- N_OUT, 10, number of output neurons (classes).
- CNT_WIDTH, 16, width of each per-neuron spike counter.
- N_STEPS, 25, number of time steps in one inference; must match the reader's sample count.
- CLS_W, $clog2(N_OUT), width of the class index.
- STEP_W, $clog2(N_STEPS+1), width of the step counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- test_mode_i  in  1  DFT hook; no functional effect.
- start_i  in  1  inference start pulse, same pulse the reader drives to the core.
- clear_i  in  1  software abort/acknowledge pulse from the ctrl register.
- out_valid_i  in  1  core output valid, one pulse per time step.
- out_spikes_i  in  N_OUT  output-layer spike vector; sampled only when out_valid_i=1.
- done_i  in  1  core end-of-inference pulse.
- counts_o  out  N_OUT*CNT_WIDTH  neuron k count at [(k+1)*CNT_WIDTH-1 -: CNT_WIDTH].
- class_o  out  CLS_W  winning neuron index.
- max_count_o  out  CNT_WIDTH  count of the winning neuron.
- steps_o  out  STEP_W  time steps accumulated this inference.
- busy_o  out  1  high in ACCUM or SCAN.
- result_valid_o  out  1  high in DONE.
- overflow_o  out  1  sticky flag: any counter saturated this inference.
- irq_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE. All outputs are 0; all counters, the step counter and the scan registers are 0. Reset is legal mid-operation and aborts immediately.
- FSM states: IDLE, ACCUM, SCAN, DONE. All outputs are registered.
- IDLE:
  - start_i=1: clear counts, steps, overflow, class_o and max_count_o; go to ACCUM next cycle.
  - All other inputs are ignored.
- ACCUM:
  - On each out_valid_i=1 cycle, for every k, count[k] += out_spikes_i[k].
  - Counters saturate at 2^CNT_WIDTH-1. An increment at saturation sets overflow_o.
  - Each out_valid_i=1 cycle increments steps.
  - Exit to SCAN on the cycle after either (a) out_valid_i accepted with steps reaching N_STEPS, or (b) done_i=1.
  - If out_valid_i and done_i coincide, the sample is accumulated first, then the block exits.
  - out_valid_i in the cycle start_i is accepted is not counted.
- SCAN:
  - Index i runs 0..N_OUT-1, one neuron per cycle, for N_OUT cycles.
  - Neuron 0 loads the best value unconditionally. Neuron i replaces the best only if count[i] is strictly greater, so ties resolve to the lowest index.
  - out_valid_i and done_i are ignored.
  - After index N_OUT-1, go to DONE.
  - class_o and max_count_o update only on entry to DONE.
- Latency: final accumulating cycle T; SCAN occupies T+1..T+N_OUT; DONE from T+N_OUT+1.
- DONE:
  - result_valid_o=1.
  - irq_o=1 only on the first DONE cycle.
  - Outputs hold until clear_i (go to IDLE, result_valid_o=0, counts retained for readback) or start_i (behaves as in IDLE, go to ACCUM).
- clear_i has priority in every state and always returns to IDLE next cycle.
  - From ACCUM/SCAN: counts and steps are zeroed, and no irq is issued.
  - From DONE: counts are retained.
- start_i in ACCUM or SCAN is ignored; there is no restart mid-inference.
- busy_o = (state==ACCUM || state==SCAN).
- done_i with steps=0 is legal: SCAN runs and reports class 0, count 0.

Test Plan:
- Basic: start_i; 25 out_valid pulses, neuron 3 spiking on 20 steps, neuron 7 on 5, others 0 -> counts[3]=20, counts[7]=5, class_o=3, max_count_o=20, steps_o=25; irq_o high exactly one cycle, 11 cycles after the last valid; result_valid_o holds.
- Tie: neurons 2 and 6 spike on all 25 steps -> class_o=2, max_count_o=25.
- Saturation: CNT_WIDTH=4, N_STEPS=25, neuron 0 spikes every step -> counts[0]=15, overflow_o=1, class_o=0.
- Early done plus coincidence: done_i on the same cycle as the 8th out_valid, neuron 5 spiking every step -> counts[5]=8, steps_o=8, SCAN entered next cycle.
- Abort: clear_i during the 10th step of ACCUM -> IDLE next cycle, busy_o=0, no irq_o, counts and steps 0; a following start_i plus full run completes normally.
- Reset mid-SCAN: rst_ni low during the 4th scan cycle -> all outputs 0 immediately, IDLE after release; start_i ignored while busy in a separate run.
